// File: rtl/serial_addsub_ctrl_311.sv
// serial_addsub_ctrl_311
//   Bit-serial adder/subtractor. A single 1-bit full-adder cell is reused once
//   per RUN cycle, so one operation takes WIDTH cycles in RUN, one in DONE,
//   and the done pulse follows in the first IDLE cycle after DONE.
//
// Ports
//   clk   : clock, all state updates on the rising edge
//   rst   : synchronous active-high reset
//   start : operation request, only looked at in IDLE
//   sub   : 0 = a + b, 1 = a - b (captured with start)
//   a, b  : WIDTH-bit operands (captured with start)
//   busy  : high while the FSM is in RUN
//   done  : one-cycle completion pulse (registered from the DONE state)
//   sum   : result register; shows partial shift contents while busy
//   cout  : final carry out (subtract: 1 = no borrow)
//   ovf   : two's-complement overflow flag
module serial_addsub_ctrl_311 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    count_q, count_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  // Shared full-adder cell: two half adders plus an OR.
  logic ha1_s, ha1_c, ha2_c, fa_s, fa_c;

  always_comb begin
    ha1_s = a_sh_q[0] ^ b_sh_q[0];
    ha1_c = a_sh_q[0] & b_sh_q[0];
    fa_s  = ha1_s ^ carry_q;
    ha2_c = ha1_s & carry_q;
    fa_c  = ha1_c | ha2_c;
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    count_d = count_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    // done is a registered image of the DONE state, so it lands one cycle
    // after DONE, while the FSM is already back in IDLE.
    done_d  = (state_q == S_DONE);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Subtraction is a + ~b + 1: invert b and seed the carry with 1.
          a_sh_d  = a;
          b_sh_d  = sub ? ~b : b;
          carry_d = sub;
          count_d = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        carry_d = fa_c;
        if (count_q == LAST_BIT) begin
          // carry_q is the carry into the MSB at this point.
          cout_d  = fa_c;
          ovf_d   = carry_q ^ fa_c;
          state_d = S_DONE;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      count_q <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      count_q <= count_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
